// File: rtl/pe_mem_arbiter.sv
// Round-robin arbiter that shares one memory read port among NUM_REQ processing elements.
// Grants are combinational. The one-hot grant travels down an RD_LAT-deep pipeline so read data is tagged with its owner.
module pe_mem_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RD_LAT  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      arb_en,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      mem_en,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [DATA_W-1:0]         rdata,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic                      busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   ptr_d;
    logic [NUM_REQ-1:0] pipe_q [RD_LAT];
    logic [NUM_REQ-1:0] pipe_d [RD_LAT];

    logic [NUM_REQ-1:0] grant_s;
    logic [PTR_W-1:0]   win_s;
    logic [PTR_W-1:0]   idx_s;
    logic               found_s;
    logic               mem_en_s;
    logic               pipe_busy_s;

    // Search from ptr upward and wrap around. Grants are held at 0 during reset so nothing leaks out while rst is high.
    always_comb begin
        grant_s = '0;
        win_s   = '0;
        idx_s   = '0;
        found_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_s = ptr_q + PTR_W'(i);
            if (!found_s && arb_en && !rst && req[idx_s]) begin
                grant_s[idx_s] = 1'b1;
                win_s          = idx_s;
                found_s        = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    always_comb begin
        mem_en_s = |grant_s;
        if (mem_en_s) begin
            ptr_d = win_s + PTR_W'(1);
        end else begin
            ptr_d = ptr_q;
        end
        pipe_d[0] = grant_s;
        for (int k = 1; k < RD_LAT; k++) begin
            pipe_d[k] = pipe_q[k-1];
        end
        pipe_busy_s = 1'b0;
        for (int k = 0; k < RD_LAT; k++) begin
            pipe_busy_s = pipe_busy_s | (|pipe_q[k]);
        end
    end

    // On reset, clear the return pipeline so that reads already in flight never produce rvalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_q[k] <= pipe_d[k];
            end
        end
    end

    always_comb begin
        grant  = grant_s;
        mem_en = mem_en_s;
        if (mem_en_s) begin
            mem_addr = req_addr[int'(win_s)*ADDR_W +: ADDR_W];
        end else begin
            mem_addr = '0;
        end
        rdata  = mem_rdata;
        rvalid = pipe_q[RD_LAT-1];
        busy   = (pipe_busy_s | mem_en_s) & ~rst;
    end

endmodule

// File: tb/tb_pe_mem_arbiter.sv
// Scoreboard bench for pe_mem_arbiter (4 requesters, read latency 2).
// Stimulus pushes the expected grants and returns into queues, and a negedge monitor pops each entry and compares it.
module tb_pe_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct { logic [3:0] g; logic [31:0] a; int c; } gexp_t;
    typedef struct { logic [3:0] g; int c; logic [31:0] d; } rexp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            arb_en;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    grant;
    logic            mem_en;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_rdata;
    logic [DW-1:0]   rdata;
    logic [N-1:0]    rvalid;
    logic            busy;
    logic [31:0]     md0, md1;

    int    cyc = 0;
    int    passed = 0;
    int    total = 0;
    int    mp = 0;
    bit    starve_on = 1'b0;
    int    last_g3 = 0;
    gexp_t gq[$];
    rexp_t rq[$];

    pe_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) dut (
        .clk(clk), .rst(rst), .arb_en(arb_en), .req(req), .req_addr(req_addr),
        .grant(grant), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .rdata(rdata), .rvalid(rvalid), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory with a 2-cycle read latency; each word is its address XOR a fixed tag.
    always @(posedge clk) begin
        md0 <= mem_addr ^ 32'hA5A5_0000;
        md1 <= md0;
    end
    assign mem_rdata = md1;
    assign req_addr  = {32'h0000_0080, 32'h0000_0040, 32'h0000_0020, 32'h0000_0010};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int widx(input logic [3:0] g);
        int r = 0;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    function automatic logic [3:0] model_grant(input logic [3:0] r);
        logic [3:0] res = 4'b0000;
        int j;
        for (int k = 3; k >= 0; k--) begin
            j = (mp + k) % 4;
            if (r[j]) res = 4'(1 << j);
        end
        return res;
    endfunction

    task automatic push_exp(input logic [3:0] eg, input bit rv);
        int w;
        if (eg != 4'b0000) begin
            w = widx(eg);
            gq.push_back('{eg, 32'h10 << w, cyc});
            if (rv) rq.push_back('{eg, cyc + 2, (32'h10 << w) ^ 32'hA5A5_0000});
            mp = (w + 1) % 4;
        end
    endtask

    task automatic drive(input logic en, input logic [3:0] r, input logic [3:0] eg, input bit rv = 1'b1);
        @(posedge clk);
        #1;
        arb_en = en;
        req    = r;
        push_exp(eg, rv);
    endtask

    // The monitor compares whatever the DUT presents against the head of each queue.
    always @(negedge clk) begin
        gexp_t ge;
        rexp_t re;
        if (mem_en) begin
            check("grant_onehot", 32'($onehot(grant)), 32'd1);
            if (gq.size() == 0) begin
                check("spurious_grant", 32'(grant), 32'd0);
            end else begin
                ge = gq.pop_front();
                check("grant", 32'(grant), 32'(ge.g));
                check("mem_addr", mem_addr, ge.a);
                check("grant_cycle", cyc, ge.c);
            end
            if (starve_on && grant[3]) begin
                check("pe3_window", 32'(cyc - last_g3 <= 4), 32'd1);
                last_g3 = cyc;
            end
        end else begin
            check("grant_idle", 32'(grant), 32'd0);
            check("mem_addr_idle", mem_addr, 32'd0);
        end
        if (rvalid != 4'b0000) begin
            if (rq.size() == 0) begin
                check("spurious_rvalid", 32'(rvalid), 32'd0);
            end else begin
                re = rq.pop_front();
                check("rvalid", 32'(rvalid), 32'(re.g));
                check("rvalid_cycle", cyc, re.c);
                check("rdata", rdata, re.d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r;
        logic [3:0] eg;
        rst = 1'b1; arb_en = 1'b1; req = 4'b1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Round robin from reset: the first cycle after release arbitrates with ptr=0.
        @(posedge clk); #1;
        rst = 1'b0; mp = 0;
        push_exp(4'b0001, 1'b1);
        drive(1'b1, 4'b1111, 4'b0010);
        drive(1'b1, 4'b1111, 4'b0100);
        drive(1'b1, 4'b1111, 4'b1000);
        drive(1'b1, 4'b1111, 4'b0001);
        drive(1'b1, 4'b1111, 4'b0010);
        drive(1'b1, 4'b1111, 4'b0100);
        drive(1'b1, 4'b1111, 4'b1000);
        @(negedge clk);
        check("busy_active", 32'(busy), 32'd1);
        drive(1'b0, 4'b0000, 4'b0000);
        drive(1'b0, 4'b0000, 4'b0000);
        drive(1'b0, 4'b0000, 4'b0000);
        @(negedge clk);
        check("busy_drained", 32'(busy), 32'd0);

        // Single request, then wrap past PE3 and skip PE1..2.
        drive(1'b1, 4'b0100, 4'b0100);
        drive(1'b1, 4'b0101, 4'b0001);
        drive(1'b1, 4'b0100, 4'b0100);

        // Enable gating: the in-flight PE1 read must still complete.
        drive(1'b1, 4'b0010, 4'b0010);
        drive(1'b0, 4'b1111, 4'b0000);
        @(negedge clk);
        check("gated_mem_en", 32'(mem_en), 32'd0);
        check("gated_busy", 32'(busy), 32'd1);
        drive(1'b0, 4'b1111, 4'b0000);
        drive(1'b0, 4'b1111, 4'b0000);
        @(negedge clk);
        check("gated_busy_done", 32'(busy), 32'd0);
        drive(1'b1, 4'b1111, 4'b0100);
        drive(1'b0, 4'b0000, 4'b0000);
        drive(1'b0, 4'b0000, 4'b0000);
        drive(1'b0, 4'b0000, 4'b0000);

        // Reset mid-flight: the PE0 read is discarded and ptr restarts at 0.
        drive(1'b1, 4'b0001, 4'b0001, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1; req = 4'b0000; arb_en = 1'b0; mp = 0;
        @(negedge clk);
        check("midrst_rvalid", 32'(rvalid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, 4'b0000, 4'b0000);
        drive(1'b0, 4'b0000, 4'b0000);
        drive(1'b1, 4'b1111, 4'b0001);
        drive(1'b0, 4'b0000, 4'b0000);
        drive(1'b0, 4'b0000, 4'b0000);

        // Starvation: PE3 holds req while PE0..2 toggle randomly.
        for (int i = 0; i < 1000; i++) begin
            r  = {1'b1, 3'($urandom_range(0, 7))};
            eg = model_grant(r);
            drive(1'b1, r, eg);
            if (i == 0) begin
                starve_on = 1'b1;
                last_g3   = cyc - 1;
            end
        end
        drive(1'b0, 4'b0000, 4'b0000);
        starve_on = 1'b0;
        drive(1'b0, 4'b0000, 4'b0000);
        drive(1'b0, 4'b0000, 4'b0000);
        @(negedge clk);
        check("grant_queue_empty", 32'(gq.size()), 32'd0);
        check("rvalid_queue_empty", 32'(rq.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
